circ_buff_mp: RTL and testbench

Multi-port successor to the single-push/single-pull instruction-fetch-queue circular buffer. It accepts up to WR_PORTS entries and delivers up to RD_PORTS entries per clock, so the superscalar front end can enqueue and dequeue fetch bundles several at a time. It tracks exact occupancy and exposes free-slot count, per-lane valid, full and empty. It sits between the fetch unit (push side) and the decode/dispatch stage (pull side).

---
 rtl/circ_buff_mp_if.sv | 46 ++++
 rtl/circ_buff_mp.sv | 111 +++++++++++
 tb/tb_circ_buff_mp.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/circ_buff_mp_if.sv
// Bus bundle for circ_buff_mp: push/pull requests, read lanes and occupancy status.
// Optional CIRC_BUFF_ERR_EN adds the sticky ovf_err/unf_err status lines.
interface circ_buff_mp_if #(
    parameter int LENGTH   = 128,
    parameter int SIZE     = 8,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2
);
    localparam int PW  = $clog2(SIZE);
    localparam int CW  = $clog2(SIZE + 1);
    localparam int PCW = $clog2(WR_PORTS + 1);
    localparam int QCW = $clog2(RD_PORTS + 1);

    logic                         flush;
    logic [PCW-1:0]               push_cnt;
    logic [WR_PORTS*LENGTH-1:0]   data_write;
    logic [QCW-1:0]               pull_cnt;
    logic [RD_PORTS*LENGTH-1:0]   data_read;
    logic [RD_PORTS-1:0]          rd_valid;
    logic [CW-1:0]                count;
    logic [CW-1:0]                free_slots;
    logic                         full;
    logic                         empty;
    logic [PW-1:0]                write_ptr;
    logic [PW-1:0]                read_ptr;
`ifdef CIRC_BUFF_ERR_EN
    logic                         ovf_err;
    logic                         unf_err;
`endif

    modport master (
        output flush, push_cnt, data_write, pull_cnt,
        input  data_read, rd_valid, count, free_slots, full, empty, write_ptr, read_ptr
`ifdef CIRC_BUFF_ERR_EN
        , input ovf_err, unf_err
`endif
    );

    modport slave (
        input  flush, push_cnt, data_write, pull_cnt,
        output data_read, rd_valid, count, free_slots, full, empty, write_ptr, read_ptr
`ifdef CIRC_BUFF_ERR_EN
        , output ovf_err, unf_err
`endif
    );
endinterface

// File: rtl/circ_buff_mp.sv
// Multi-port circular instruction-fetch queue: up to WR_PORTS pushes and RD_PORTS pulls per clock.
// Define CIRC_BUFF_ERR_EN to add sticky overflow/underflow error flags.
module circ_buff_mp #(
    parameter int LENGTH   = 128,
    parameter int SIZE     = 8,
    parameter int WR_PORTS = 2,
    parameter int RD_PORTS = 2
) (
    input logic           clk,
    input logic           rst,
    circ_buff_mp_if.slave bus
);
    localparam int PW  = $clog2(SIZE);
    localparam int CW  = $clog2(SIZE + 1);
    localparam int PCW = $clog2(WR_PORTS + 1);
    localparam int QCW = $clog2(RD_PORTS + 1);

    localparam logic [PCW-1:0] WR_MAX = PCW'(WR_PORTS);
    localparam logic [QCW-1:0] RD_MAX = QCW'(RD_PORTS);
    localparam logic [CW-1:0]  DEPTH  = CW'(SIZE);

    logic [LENGTH-1:0] buff [SIZE];
    logic [PW-1:0]     read_ptr_q;
    logic [PW-1:0]     write_ptr_q;
    logic [CW-1:0]     count_q;
    logic              full_q;
    logic              empty_q;

    logic [CW-1:0]     push_req;
    logic [CW-1:0]     pull_req;
    logic [CW-1:0]     space;
    logic [CW-1:0]     acc_push;
    logic [CW-1:0]     acc_pull;
    logic [CW-1:0]     count_next;

    // Acceptance uses start-of-cycle occupancy: a same-cycle pull never frees room for a push.
    always_comb begin
        push_req   = (bus.push_cnt > WR_MAX) ? CW'(WR_MAX) : CW'(bus.push_cnt);
        pull_req   = (bus.pull_cnt > RD_MAX) ? CW'(RD_MAX) : CW'(bus.pull_cnt);
        space      = DEPTH - count_q;
        acc_push   = (push_req < space)   ? push_req : space;
        acc_pull   = (pull_req < count_q) ? pull_req : count_q;
        count_next = count_q + acc_push - acc_pull;
    end

    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        bus.data_read = '0;
        bus.rd_valid  = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            bus.data_read[i*LENGTH +: LENGTH] = buff[read_ptr_q + PW'(i)];
            bus.rd_valid[i]                   = CW'(i) < count_q;
        end
    end

    assign bus.count      = count_q;
    assign bus.free_slots = DEPTH - count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.write_ptr  = write_ptr_q;
    assign bus.read_ptr   = read_ptr_q;

    // Pointer sums stay PW bits wide, so they wrap modulo SIZE with no explicit compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            // NOTE: storage is cleared on rst so data_read is a known zero afterwards; flush leaves it alone.
            buff        <= '{default: '0};
        end else if (bus.flush) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            for (int i = 0; i < WR_PORTS; i++) begin
                if (CW'(i) < acc_push) begin
                    buff[write_ptr_q + PW'(i)] <= bus.data_write[i*LENGTH +: LENGTH];
                end
            end
            write_ptr_q <= write_ptr_q + acc_push[PW-1:0];
            read_ptr_q  <= read_ptr_q + acc_pull[PW-1:0];
            count_q     <= count_next;
            full_q      <= count_next == DEPTH;
            empty_q     <= count_next == '0;
        end
    end

`ifdef CIRC_BUFF_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Raw, unclamped requests are compared so any offer beyond the room is reported.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (CW'(bus.push_cnt) > space)   ovf_q <= 1'b1;
            if (CW'(bus.pull_cnt) > count_q) unf_q <= 1'b1;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
`endif
endmodule

// File: tb/tb_circ_buff_mp.sv
// Self-checking bench for circ_buff_mp: directed scenarios plus randomized traffic
// compared against a slot-array/occupancy reference model.
module tb_circ_buff_mp;
    localparam int LENGTH = 128;
    localparam int SIZE   = 8;
    localparam int WR     = 2;
    localparam int RD     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    circ_buff_mp_if #(.LENGTH(LENGTH), .SIZE(SIZE), .WR_PORTS(WR), .RD_PORTS(RD)) bus ();
    circ_buff_mp #(.LENGTH(LENGTH), .SIZE(SIZE), .WR_PORTS(WR), .RD_PORTS(RD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: absolute slot contents plus read/write positions and occupancy.
    logic [LENGTH-1:0] m_mem [SIZE];
    int m_rp  = 0;
    int m_wp  = 0;
    int m_cnt = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    initial begin
        bus.flush      = 1'b0;
        bus.push_cnt   = '0;
        bus.pull_cnt   = '0;
        bus.data_write = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
    end

    // Applies one clock of stimulus, then advances the model by the same rules.
    task automatic cycle(input int p, input int q, input bit fl, input bit r,
                         input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b);
        int room;
        int ap;
        int aq;
        @(negedge clk);
        rst            = r;
        bus.flush      = fl;
        bus.push_cnt   = 2'(p);
        bus.pull_cnt   = 2'(q);
        bus.data_write = {b, a};
        @(posedge clk);
        if (r) begin
            m_rp = 0; m_wp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (fl) begin
            m_rp = 0; m_wp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            room = SIZE - m_cnt;
            ap = (p > WR) ? WR : p;
            aq = (q > RD) ? RD : q;
            if (ap > room)  ap = room;
            if (aq > m_cnt) aq = m_cnt;
            if (p > room)   m_ovf = 1;
            if (q > m_cnt)  m_unf = 1;
            if (ap > 0) m_mem[m_wp] = a;
            if (ap > 1) m_mem[(m_wp + 1) % SIZE] = b;
            m_wp  = (m_wp + ap) % SIZE;
            m_rp  = (m_rp + aq) % SIZE;
            m_cnt = m_cnt + ap - aq;
        end
        #1;
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.push_cnt = '0;
        bus.pull_cnt = '0;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 1, '0, '0);
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if ({bus.empty, bus.full} !== 2'b10) begin bad++; $display("FAIL reset_flags got=%b want=10", {bus.empty, bus.full}); end
        total++; if (bus.free_slots !== 4'd8) begin bad++; $display("FAIL reset_free got=%0d want=8", bus.free_slots); end
        // Reset mid-traffic with five entries held and push/pull requested on the reset edge.
        cycle(2, 0, 0, 0, 128'h11, 128'h12);
        cycle(2, 0, 0, 0, 128'h13, 128'h14);
        cycle(1, 0, 0, 0, 128'h15, 128'h0);
        total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL pre_rst_count got=%0d want=5", bus.count); end
        cycle(2, 1, 0, 1, 128'h16, 128'h17);
        total++; if ({bus.count, bus.empty, bus.write_ptr, bus.read_ptr} !== {4'd0, 1'b1, 3'd0, 3'd0}) begin
            bad++; $display("FAIL rst_mid_state got cnt=%0d empty=%b wp=%0d rp=%0d want 0/1/0/0",
                            bus.count, bus.empty, bus.write_ptr, bus.read_ptr);
        end
        total++; if (bus.data_read !== 256'h0 || bus.rd_valid !== 2'b00) begin
            bad++; $display("FAIL rst_mid_data got data=%0h valid=%b want 0/00", bus.data_read, bus.rd_valid);
        end
    endtask

    task automatic test_fill_drain();
        cycle(0, 0, 1, 0, '0, '0);
        for (int k = 0; k < 4; k++) cycle(2, 0, 0, 0, 128'(2*k + 1), 128'(2*k + 2));
        total++; if ({bus.count, bus.full, bus.write_ptr, bus.free_slots} !== {4'd8, 1'b1, 3'd0, 4'd0}) begin
            bad++; $display("FAIL fill_state got cnt=%0d full=%b wp=%0d free=%0d want 8/1/0/0",
                            bus.count, bus.full, bus.write_ptr, bus.free_slots);
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.data_read !== {128'(2*k + 2), 128'(2*k + 1)} || bus.rd_valid !== 2'b11) begin
                bad++; $display("FAIL drain_pair%0d got=%0h valid=%b want lanes %0d,%0d valid 11",
                                k, bus.data_read, bus.rd_valid, 2*k + 1, 2*k + 2);
            end
            cycle(0, 2, 0, 0, '0, '0);
        end
        total++; if ({bus.empty, bus.count} !== {1'b1, 4'd0}) begin
            bad++; $display("FAIL drain_empty got empty=%b cnt=%0d want 1/0", bus.empty, bus.count);
        end
    endtask

    task automatic test_overflow();
        cycle(0, 0, 1, 0, '0, '0);
        for (int k = 0; k < 3; k++) cycle(2, 0, 0, 0, 128'(2*k + 1), 128'(2*k + 2));
        cycle(1, 0, 0, 0, 128'd7, '0);
        cycle(2, 0, 0, 0, 128'hA, 128'hB);
        total++; if ({bus.count, bus.full, bus.write_ptr} !== {4'd8, 1'b1, 3'd0}) begin
            bad++; $display("FAIL ovf_state got cnt=%0d full=%b wp=%0d want 8/1/0", bus.count, bus.full, bus.write_ptr);
        end
        total++; if (bus.data_read[LENGTH-1:0] !== 128'd1) begin
            bad++; $display("FAIL ovf_slot0_kept got=%0h want=1", bus.data_read[LENGTH-1:0]);
        end
`ifdef CIRC_BUFF_ERR_EN
        total++; if (bus.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b want=1", bus.ovf_err); end
`endif
        for (int k = 0; k < 3; k++) cycle(0, 2, 0, 0, '0, '0);
        total++; if (bus.data_read !== {128'hA, 128'd7}) begin
            bad++; $display("FAIL ovf_tail got=%0h want lanes 7,A", bus.data_read);
        end
    endtask

    task automatic test_underflow();
        cycle(0, 0, 1, 0, '0, '0);
`ifdef CIRC_BUFF_ERR_EN
        total++; if (bus.ovf_err !== 1'b0) begin bad++; $display("FAIL flush_ovf_clear got=%b want=0", bus.ovf_err); end
`endif
        cycle(1, 0, 0, 0, 128'hC, '0);
        total++; if (bus.rd_valid !== 2'b01 || bus.count !== 4'd1) begin
            bad++; $display("FAIL unf_pre got valid=%b cnt=%0d want 01/1", bus.rd_valid, bus.count);
        end
        cycle(0, 2, 0, 0, '0, '0);
        total++; if ({bus.count, bus.empty, bus.read_ptr} !== {4'd0, 1'b1, 3'd1}) begin
            bad++; $display("FAIL unf_post got cnt=%0d empty=%b rp=%0d want 0/1/1", bus.count, bus.empty, bus.read_ptr);
        end
`ifdef CIRC_BUFF_ERR_EN
        total++; if (bus.unf_err !== 1'b1) begin bad++; $display("FAIL unf_err got=%b want=1", bus.unf_err); end
`endif
    endtask

    task automatic test_full_both();
        logic [LENGTH-1:0] exp_order [8];
        exp_order = '{128'd13, 128'd14, 128'd15, 128'd16, 128'd17, 128'd18, 128'd23, 128'd24};
        cycle(0, 0, 1, 0, '0, '0);
        for (int k = 0; k < 4; k++) cycle(2, 0, 0, 0, 128'(11 + 2*k), 128'(12 + 2*k));
        cycle(2, 2, 0, 0, 128'd21, 128'd22);
        total++; if ({bus.count, bus.read_ptr, bus.write_ptr, bus.full} !== {4'd6, 3'd2, 3'd0, 1'b0}) begin
            bad++; $display("FAIL full_both got cnt=%0d rp=%0d wp=%0d full=%b want 6/2/0/0",
                            bus.count, bus.read_ptr, bus.write_ptr, bus.full);
        end
        cycle(2, 0, 0, 0, 128'd23, 128'd24);
        total++; if ({bus.count, bus.write_ptr, bus.full} !== {4'd8, 3'd2, 1'b1}) begin
            bad++; $display("FAIL wrap_push got cnt=%0d wp=%0d full=%b want 8/2/1", bus.count, bus.write_ptr, bus.full);
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.data_read !== {exp_order[2*k + 1], exp_order[2*k]}) begin
                bad++; $display("FAIL wrap_order%0d got=%0h want lanes %0h,%0h",
                                k, bus.data_read, exp_order[2*k], exp_order[2*k + 1]);
            end
            cycle(0, 2, 0, 0, '0, '0);
        end
    endtask

    task automatic test_flush();
        cycle(0, 0, 1, 0, '0, '0);
        cycle(2, 0, 0, 0, 128'h31, 128'h32);
        cycle(2, 0, 0, 0, 128'h33, 128'h34);
        cycle(2, 0, 1, 0, 128'h35, 128'h36);
        total++; if ({bus.count, bus.empty, bus.read_ptr, bus.write_ptr, bus.rd_valid} !== {4'd0, 1'b1, 3'd0, 3'd0, 2'b00}) begin
            bad++; $display("FAIL flush_state got cnt=%0d empty=%b rp=%0d wp=%0d valid=%b want 0/1/0/0/00",
                            bus.count, bus.empty, bus.read_ptr, bus.write_ptr, bus.rd_valid);
        end
        total++; if (bus.data_read[LENGTH-1:0] !== 128'h31) begin
            bad++; $display("FAIL flush_keeps_storage got=%0h want=31", bus.data_read[LENGTH-1:0]);
        end
        cycle(1, 0, 0, 0, 128'hDEAD_BEEF, 128'h77);
        total++; if (bus.data_read[LENGTH-1:0] !== 128'hDEAD_BEEF || bus.count !== 4'd1 || bus.write_ptr !== 3'd1) begin
            bad++; $display("FAIL flush_then_push got lane0=%0h cnt=%0d wp=%0d want deadbeef/1/1",
                            bus.data_read[LENGTH-1:0], bus.count, bus.write_ptr);
        end
    endtask

    task automatic test_random();
        logic [17:0]         exp_st;
        logic [17:0]         got_st;
        logic [2*LENGTH-1:0] exp_data;
        int p;
        int q;
        for (int n = 0; n < 400; n++) begin
            // Alternate fill-leaning and drain-leaning phases so full and empty are both visited.
            if ((n / 40) % 2 == 0) begin p = $urandom_range(1, 3); q = $urandom_range(0, 2); end
            else                   begin p = $urandom_range(0, 2); q = $urandom_range(1, 3); end
            cycle(p, q, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0,
                  {$urandom(), $urandom(), $urandom(), $urandom()},
                  {$urandom(), $urandom(), $urandom(), $urandom()});
            exp_st = {4'(m_cnt), 4'(SIZE - m_cnt), m_cnt == SIZE, m_cnt == 0,
                      3'(m_wp), 3'(m_rp), m_cnt > 1, m_cnt > 0};
            got_st = {bus.count, bus.free_slots, bus.full, bus.empty,
                      bus.write_ptr, bus.read_ptr, bus.rd_valid};
            exp_data = {m_mem[(m_rp + 1) % SIZE], m_mem[m_rp]};
            total++; if (got_st !== exp_st) begin
                bad++; $display("FAIL rand_state cyc=%0d got=%h want=%h (cnt,free,full,empty,wp,rp,valid)", n, got_st, exp_st);
            end
            total++; if (bus.data_read !== exp_data) begin
                bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", n, bus.data_read, exp_data);
            end
`ifdef CIRC_BUFF_ERR_EN
            total++; if ({bus.ovf_err, bus.unf_err} !== {m_ovf, m_unf}) begin
                bad++; $display("FAIL rand_err cyc=%0d got=%b want=%b", n, {bus.ovf_err, bus.unf_err}, {m_ovf, m_unf});
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_full_both();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
